// File: rtl/synth_bus_pkg.sv
// rtl/synth_bus_pkg.sv - shared encodings for the channel bus sequencer
// Holds register offsets, command type and FSM state encodings, the queued
// command layout and the channel address helper.
package synth_bus_pkg;

    localparam logic [15:0] OFS_GATE  = 16'd0;
    localparam logic [15:0] OFS_INCR0 = 16'd1;
    localparam logic [15:0] OFS_INCR1 = 16'd2;
    localparam logic [15:0] OFS_INCR2 = 16'd3;

    localparam logic [15:0] IDLE_ADDR  = 16'hFFFF;
    localparam int          FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        CMD_NOTE_ON  = 2'b00,
        CMD_NOTE_OFF = 2'b01,
        CMD_SET_INCR = 2'b10,
        CMD_RSVD     = 2'b11
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INCR0 = 3'd1,
        ST_INCR1 = 3'd2,
        ST_INCR2 = 3'd3,
        ST_GATE  = 3'd4
    } state_e;

    typedef struct packed {
        cmd_type_e   ctype;
        logic [3:0]  ch;
        logic [23:0] incr;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Register block base of a channel; wraps modulo 2^16 by construction.
    function automatic logic [15:0] chan_addr(input logic [15:0] base,
                                              input logic [15:0] stride,
                                              input logic [3:0]  ch);
        return base + ({12'd0, ch} * stride);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - small synchronous command FIFO with registered ready
// Ports: clk, resetn (sync, active-low), push/wdata (write side),
// pop/rdata (read side, first-word fall-through), ready (not full), empty.
module cmd_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Ready is registered from the post-edge occupancy, so a full FIFO
        // never accepts a push even if it pops on the same edge.
        do_push  = push & ready_q;
        do_pop   = pop & (count_q != '0);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign ready = ready_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/channel_bus_sequencer.sv
// rtl/channel_bus_sequencer.sv - turns queued channel commands into bus write cycles
// Ports: BusClock, Reset (sync, active-low); command side CmdValid/CmdReady,
// CmdType, CmdChannel, CmdIncr; bus side BusAddress, BusData, BusReadWrite
// (all registered); status Busy and saturating DropCount.
module channel_bus_sequencer #(
    parameter int          NUM_CHANNELS   = 8,
    parameter logic [15:0] CHANNEL_BASE   = 16'h0000,
    parameter logic [15:0] CHANNEL_STRIDE = 16'h0020
) (
    input  logic        BusClock,
    input  logic        Reset,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [1:0]  CmdType,
    input  logic [3:0]  CmdChannel,
    input  logic [23:0] CmdIncr,
    output logic [15:0] BusAddress,
    output logic [7:0]  BusData,
    output logic        BusReadWrite,
    output logic        Busy,
    output logic [7:0]  DropCount
);

    import synth_bus_pkg::*;

    localparam logic [4:0] NCH = 5'(NUM_CHANNELS);

    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_ready;
    logic             fifo_empty;
    logic             pop;
    cmd_t             head;

    state_e      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [23:0] incr_q, incr_d;
    logic        gate_on_q, gate_on_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        wr_q, wr_d;
    logic [7:0]  drop_q, drop_d;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (BusClock),
        .resetn (Reset),
        .push   (CmdValid & fifo_ready),
        .wdata  ({CmdType, CmdChannel, CmdIncr}),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .ready  (fifo_ready),
        .empty  (fifo_empty)
    );

    assign head = cmd_t'(fifo_rdata);

    // Bus values are computed for the state being entered and registered,
    // so each state's write is stable for the whole following cycle.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        incr_d    = incr_q;
        gate_on_d = gate_on_q;
        addr_d    = IDLE_ADDR;
        data_d    = 8'h00;
        wr_d      = 1'b0;
        drop_d    = drop_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.ctype == CMD_RSVD || {1'b0, head.ch} >= NCH) begin
                        if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end else begin
                        base_d    = chan_addr(CHANNEL_BASE, CHANNEL_STRIDE, head.ch);
                        incr_d    = head.incr;
                        gate_on_d = (head.ctype == CMD_NOTE_ON);
                        wr_d      = 1'b1;
                        if (head.ctype == CMD_NOTE_OFF) begin
                            state_d = ST_GATE;
                            addr_d  = base_d + OFS_GATE;
                            data_d  = 8'h00;
                        end else begin
                            state_d = ST_INCR0;
                            addr_d  = base_d + OFS_INCR0;
                            data_d  = head.incr[7:0];
                        end
                    end
                end
            end
            ST_INCR0: begin
                state_d = ST_INCR1;
                addr_d  = base_q + OFS_INCR1;
                data_d  = incr_q[15:8];
                wr_d    = 1'b1;
            end
            ST_INCR1: begin
                state_d = ST_INCR2;
                addr_d  = base_q + OFS_INCR2;
                data_d  = incr_q[23:16];
                wr_d    = 1'b1;
            end
            ST_INCR2: begin
                // SET_INCR ends here; NOTE_ON still owes its gate write.
                if (gate_on_q) begin
                    state_d = ST_GATE;
                    addr_d  = base_q + OFS_GATE;
                    data_d  = 8'h01;
                    wr_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge BusClock) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            base_q    <= 16'h0000;
            incr_q    <= 24'h000000;
            gate_on_q <= 1'b0;
            addr_q    <= IDLE_ADDR;
            data_q    <= 8'h00;
            wr_q      <= 1'b0;
            drop_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            incr_q    <= incr_d;
            gate_on_q <= gate_on_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            drop_q    <= drop_d;
        end
    end

    assign CmdReady     = fifo_ready;
    assign BusAddress   = addr_q;
    assign BusData      = data_q;
    assign BusReadWrite = wr_q;
    assign DropCount    = drop_q;
    assign Busy         = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_channel_bus_sequencer.sv
// tb/tb_channel_bus_sequencer.sv - self-checking bench for channel_bus_sequencer
module tb_channel_bus_sequencer;

    logic        BusClock = 1'b0;
    logic        Reset = 1'b0;
    logic        CmdValid = 1'b0;
    logic        CmdValid2 = 1'b0;
    logic [1:0]  CmdType = 2'b00;
    logic [3:0]  CmdChannel = 4'd0;
    logic [23:0] CmdIncr = 24'd0;

    logic        CmdReady1, BusReadWrite1, Busy1;
    logic [15:0] BusAddress1;
    logic [7:0]  BusData1, DropCount1;
    logic        CmdReady2, BusReadWrite2, Busy2;
    logic [15:0] BusAddress2;
    logic [7:0]  BusData2, DropCount2;

    int total = 0;
    int bad = 0;
    int drops_m = 0;
    int idle_bad = 0;
    bit mon_en = 0;
    bit prev_wr1 = 0;
    bit prev_wr2 = 0;

    // Entries: {first write of its command / preceded by idle, address, data}
    logic [24:0] exp1[$];
    logic [24:0] obs1[$];
    logic [24:0] exp2[$];
    logic [24:0] obs2[$];

    channel_bus_sequencer #(
        .NUM_CHANNELS(8), .CHANNEL_BASE(16'h0000), .CHANNEL_STRIDE(16'h0020)
    ) dut (
        .BusClock(BusClock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady1),
        .CmdType(CmdType), .CmdChannel(CmdChannel), .CmdIncr(CmdIncr),
        .BusAddress(BusAddress1), .BusData(BusData1), .BusReadWrite(BusReadWrite1),
        .Busy(Busy1), .DropCount(DropCount1)
    );

    channel_bus_sequencer #(
        .NUM_CHANNELS(8), .CHANNEL_BASE(16'hFFF0), .CHANNEL_STRIDE(16'h0020)
    ) dut_wrap (
        .BusClock(BusClock), .Reset(Reset), .CmdValid(CmdValid2), .CmdReady(CmdReady2),
        .CmdType(CmdType), .CmdChannel(CmdChannel), .CmdIncr(CmdIncr),
        .BusAddress(BusAddress2), .BusData(BusData2), .BusReadWrite(BusReadWrite2),
        .Busy(Busy2), .DropCount(DropCount2)
    );

    always #5 BusClock = ~BusClock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    always @(negedge BusClock) begin
        if (mon_en) begin
            if (BusReadWrite1 === 1'b1) obs1.push_back({~prev_wr1, BusAddress1, BusData1});
            else if (BusAddress1 !== 16'hFFFF || BusData1 !== 8'h00) idle_bad++;
            prev_wr1 = (BusReadWrite1 === 1'b1);
            if (BusReadWrite2 === 1'b1) obs2.push_back({~prev_wr2, BusAddress2, BusData2});
            prev_wr2 = (BusReadWrite2 === 1'b1);
        end
    end

    function automatic void add_exp(input int sel, input bit first, input int addr, input int data);
        logic [24:0] e;
        e = {first, addr[15:0], data[7:0]};
        if (sel == 0) exp1.push_back(e);
        else exp2.push_back(e);
    endfunction

    // Reference: the write list a command must produce, from plain address arithmetic.
    task automatic model_cmd(input int sel, input logic [1:0] t, input logic [3:0] ch, input logic [23:0] inc);
        int base, cb;
        bit first;
        base = (sel == 0) ? 0 : 'hFFF0;
        cb = base + int'(ch) * 32;
        if (t == 2'b11 || ch >= 4'd8) begin
            if (sel == 0 && drops_m < 255) drops_m++;
            return;
        end
        first = 1;
        if (t != 2'b01) begin
            for (int b = 0; b < 3; b++) begin
                add_exp(sel, first, (cb + 1 + b) % 65536, int'((inc >> (8 * b)) & 24'hFF));
                first = 0;
            end
        end
        if (t == 2'b00) add_exp(sel, first, cb % 65536, 1);
        else if (t == 2'b01) add_exp(sel, first, cb % 65536, 0);
    endtask

    task automatic clear_q();
        @(posedge BusClock);
        #1;
        exp1.delete(); obs1.delete(); exp2.delete(); obs2.delete();
    endtask

    task automatic push(input int sel, input logic [1:0] t, input logic [3:0] ch,
                        input logic [23:0] inc, output bit stalled);
        bit ok;
        ok = 0;
        stalled = 0;
        @(negedge BusClock);
        CmdType = t; CmdChannel = ch; CmdIncr = inc;
        if (sel == 0) CmdValid = 1'b1; else CmdValid2 = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (((sel == 0) ? CmdReady1 : CmdReady2) === 1'b1) begin
                @(posedge BusClock);
                #1;
                ok = 1;
            end else begin
                stalled = 1;
                @(negedge BusClock);
            end
        end
        CmdValid = 1'b0;
        CmdValid2 = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL push_accept: ready=%b never seen, need 1", 1'b0); end
        else model_cmd(sel, t, ch, inc);
    endtask

    task automatic wait_idle(input int sel);
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge BusClock);
            done = (sel == 0) ? (Busy1 === 1'b0 && BusReadWrite1 === 1'b0)
                              : (Busy2 === 1'b0 && BusReadWrite2 === 1'b0);
        end
        total++;
        if (!done) begin bad++; $display("FAIL wait_idle: busy still set after 400 cycles, need idle"); end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge BusClock);
        total++; if (BusReadWrite1 !== 1'b0) begin bad++; $display("FAIL reset_rw: got %b need 0", BusReadWrite1); end
        total++; if (BusAddress1 !== 16'hFFFF) begin bad++; $display("FAIL reset_addr: got %h need ffff", BusAddress1); end
        total++; if (BusData1 !== 8'h00) begin bad++; $display("FAIL reset_data: got %h need 00", BusData1); end
        total++; if (DropCount1 !== 8'h00) begin bad++; $display("FAIL reset_drop: got %h need 00", DropCount1); end
        total++; if (CmdReady1 !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b need 0", CmdReady1); end
        total++; if (Busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b need 0", Busy1); end
        Reset = 1'b1;
        mon_en = 1;
        @(negedge BusClock);
        total++; if (CmdReady1 !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b need 1", CmdReady1); end
    endtask

    task automatic test_note_on();
        logic [15:0] ea [4];
        logic [7:0]  ed [4];
        bit st;
        ea[0] = 16'h0041; ea[1] = 16'h0042; ea[2] = 16'h0043; ea[3] = 16'h0040;
        ed[0] = 8'h56;    ed[1] = 8'h34;    ed[2] = 8'h12;    ed[3] = 8'h01;
        clear_q();
        push(0, 2'b00, 4'd2, 24'h123456, st);
        @(negedge BusClock);
        total++; if ({BusReadWrite1, Busy1} !== 2'b01) begin bad++; $display("FAIL note_on_latency: rw,busy=%b need 01", {BusReadWrite1, Busy1}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge BusClock);
            total++;
            if ({BusReadWrite1, BusAddress1, BusData1} !== {1'b1, ea[i], ed[i]}) begin
                bad++; $display("FAIL note_on_write%0d: got rw=%b %h=%h need 1 %h=%h", i, BusReadWrite1, BusAddress1, BusData1, ea[i], ed[i]);
            end
        end
        @(negedge BusClock);
        total++; if (BusReadWrite1 !== 1'b0) begin bad++; $display("FAIL note_on_end: rw=%b need 0", BusReadWrite1); end
        wait_idle(0);
    endtask

    task automatic test_note_off();
        bit st;
        clear_q();
        push(0, 2'b01, 4'd0, 24'($urandom), st);
        @(negedge BusClock);
        total++; if (BusReadWrite1 !== 1'b0) begin bad++; $display("FAIL note_off_latency: rw=%b need 0", BusReadWrite1); end
        @(negedge BusClock);
        total++; if ({BusReadWrite1, BusAddress1, BusData1} !== {1'b1, 16'h0000, 8'h00}) begin
            bad++; $display("FAIL note_off_write: got rw=%b %h=%h need 1 0000=00", BusReadWrite1, BusAddress1, BusData1);
        end
        @(negedge BusClock);
        total++; if (BusReadWrite1 !== 1'b0) begin bad++; $display("FAIL note_off_end: rw=%b need 0", BusReadWrite1); end
        wait_idle(0);
    endtask

    task automatic test_back_to_back();
        bit st, stall_seen;
        stall_seen = 0;
        clear_q();
        for (int n = 0; n < 6; n++) begin
            push(0, 2'b00, 4'($urandom_range(0, 7)), 24'($urandom), st);
            stall_seen |= st;
        end
        total++; if (stall_seen !== 1'b1) begin bad++; $display("FAIL b2b_full_stall: stall=%b need 1", stall_seen); end
        wait_idle(0);
        total++; if (obs1.size() !== exp1.size()) begin bad++; $display("FAIL b2b_count: got %0d writes need %0d", obs1.size(), exp1.size()); end
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
            total++; if (obs1[i] !== exp1[i]) begin bad++; $display("FAIL b2b_write%0d: got %h need %h", i, obs1[i], exp1[i]); end
        end
    endtask

    task automatic test_drop();
        bit st;
        clear_q();
        push(0, 2'b00, 4'd9, 24'h00ABCD, st);
        wait_idle(0);
        total++; if (DropCount1 !== 8'd1) begin bad++; $display("FAIL drop_channel: got %0d need 1", DropCount1); end
        push(0, 2'b11, 4'd1, 24'h000001, st);
        wait_idle(0);
        total++; if (DropCount1 !== 8'd2) begin bad++; $display("FAIL drop_reserved: got %0d need 2", DropCount1); end
        for (int n = 0; n < 298; n++) begin
            if ($urandom_range(0, 1) == 0) push(0, 2'b11, 4'($urandom_range(0, 15)), 24'($urandom), st);
            else push(0, 2'($urandom_range(0, 2)), 4'($urandom_range(8, 15)), 24'($urandom), st);
        end
        wait_idle(0);
        total++; if (DropCount1 !== 8'hFF) begin bad++; $display("FAIL drop_saturate: got %h need ff", DropCount1); end
        total++; if (obs1.size() !== 0) begin bad++; $display("FAIL drop_no_write: got %0d writes need 0", obs1.size()); end
    endtask

    task automatic test_reset_abort();
        bit st;
        logic [23:0] inc_a;
        inc_a = 24'($urandom);
        clear_q();
        push(0, 2'b00, 4'd3, inc_a, st);
        push(0, 2'b10, 4'd5, 24'($urandom), st);
        @(negedge BusClock);
        total++; if ({BusReadWrite1, BusAddress1, BusData1} !== {1'b1, 16'h0061, inc_a[7:0]}) begin
            bad++; $display("FAIL abort_incr0: got rw=%b %h=%h need 1 0061=%h", BusReadWrite1, BusAddress1, BusData1, inc_a[7:0]);
        end
        @(negedge BusClock);
        total++; if ({BusReadWrite1, BusAddress1, BusData1} !== {1'b1, 16'h0062, inc_a[15:8]}) begin
            bad++; $display("FAIL abort_incr1: got rw=%b %h=%h need 1 0062=%h", BusReadWrite1, BusAddress1, BusData1, inc_a[15:8]);
        end
        Reset = 1'b0;
        clear_q();
        drops_m = 0;
        @(negedge BusClock);
        total++; if ({BusReadWrite1, BusAddress1, BusData1} !== {1'b0, 16'hFFFF, 8'h00}) begin
            bad++; $display("FAIL abort_idle_bus: got rw=%b %h=%h need 0 ffff=00", BusReadWrite1, BusAddress1, BusData1);
        end
        total++; if ({Busy1, CmdReady1, DropCount1} !== {1'b0, 1'b0, 8'h00}) begin
            bad++; $display("FAIL abort_status: got busy=%b ready=%b drop=%h need 0 0 00", Busy1, CmdReady1, DropCount1);
        end
        Reset = 1'b1;
        repeat (10) @(negedge BusClock);
        total++; if (obs1.size() !== 0) begin bad++; $display("FAIL abort_no_write: got %0d writes need 0", obs1.size()); end
        total++; if (Busy1 !== 1'b0) begin bad++; $display("FAIL abort_fifo_empty: busy=%b need 0", Busy1); end
    endtask

    task automatic test_wrap();
        bit st;
        clear_q();
        push(1, 2'b10, 4'd7, 24'($urandom), st);
        wait_idle(1);
        total++; if (obs2.size() !== 3) begin bad++; $display("FAIL wrap_count: got %0d writes need 3", obs2.size()); end
        for (int i = 0; i < 3 && i < obs2.size(); i++) begin
            total++; if (obs2[i][23:8] !== 16'h00D1 + 16'(i)) begin
                bad++; $display("FAIL wrap_addr%0d: got %h need %h", i, obs2[i][23:8], 16'h00D1 + 16'(i));
            end
            total++; if (obs2[i] !== exp2[i]) begin bad++; $display("FAIL wrap_write%0d: got %h need %h", i, obs2[i], exp2[i]); end
        end
    endtask

    task automatic test_random();
        bit st;
        clear_q();
        for (int n = 0; n < 40; n++) begin
            push(0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 24'($urandom), st);
            repeat ($urandom_range(0, 2)) @(negedge BusClock);
        end
        wait_idle(0);
        total++; if (obs1.size() !== exp1.size()) begin bad++; $display("FAIL rand_count: got %0d writes need %0d", obs1.size(), exp1.size()); end
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
            total++; if (obs1[i] !== exp1[i]) begin bad++; $display("FAIL rand_write%0d: got %h need %h", i, obs1[i], exp1[i]); end
        end
        total++; if (DropCount1 !== 8'(drops_m)) begin bad++; $display("FAIL rand_drop: got %0d need %0d", DropCount1, drops_m); end
        total++; if (idle_bad !== 0) begin bad++; $display("FAIL idle_bus_values: got %0d bad idle cycles need 0", idle_bad); end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_note_off();
        test_back_to_back();
        test_drop();
        test_reset_abort();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
